// File: rtl/cdb_rr_arbiter_if.sv
// Bundle of requester-side result channels and the registered CDB broadcast.
// The arbiter attaches through the slave modport; producers and consumers attach through master.
interface cdb_rr_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
);
    localparam int SRC_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                     flush;
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH*TAG_W-1:0]  ch_tag;
    logic [NUM_CH*DATA_W-1:0] ch_result;
    logic [NUM_CH*DATA_W-1:0] ch_store_data;
    logic [NUM_CH-1:0]        ch_branch;
    logic [NUM_CH-1:0]        ch_branch_taken;
    logic [NUM_CH-1:0]        ch_grant;

    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_result;
    logic [DATA_W-1:0]        cdb_store_data;
    logic                     cdb_branch;
    logic                     cdb_branch_taken;
    logic [SRC_W-1:0]         cdb_src;

    modport slave (
        input  flush, ch_req, ch_tag, ch_result, ch_store_data, ch_branch, ch_branch_taken,
        output ch_grant, cdb_valid, cdb_tag, cdb_result, cdb_store_data,
               cdb_branch, cdb_branch_taken, cdb_src
    );

    modport master (
        output flush, ch_req, ch_tag, ch_result, ch_store_data, ch_branch, ch_branch_taken,
        input  ch_grant, cdb_valid, cdb_tag, cdb_result, cdb_store_data,
               cdb_branch, cdb_branch_taken, cdb_src
    );
endinterface

// File: rtl/cdb_rr_arbiter.sv
// Common-data-bus arbiter: one combinational grant per cycle among NUM_CH result channels,
// winner's fields broadcast on a registered CDB one cycle later. Round-robin or fixed priority.
module cdb_rr_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    cdb_rr_arbiter_if.slave  bus
);
    localparam int              SRC_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [SRC_W-1:0] LAST = SRC_W'(NUM_CH - 1);

    logic [SRC_W-1:0]  ptr_q, ptr_d;
    logic [SRC_W-1:0]  start;
    logic [SRC_W-1:0]  win_idx;
    logic              found;
    logic              grant_any;
    logic [NUM_CH-1:0] grant;

    logic              valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic              branch_q, branch_d;
    logic              taken_q, taken_d;
    logic [SRC_W-1:0]  src_q, src_d;

    // Circular search from the start index; fixed-priority mode always starts at channel 0.
    always_comb begin : search
        int idx;
        idx     = 0;
        start   = (RR_MODE != 0) ? ptr_q : '0;
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(start) + k) % NUM_CH;
            if (!found && bus.ch_req[idx]) begin
                found   = 1'b1;
                win_idx = SRC_W'(idx);
            end
        end
    end

    assign grant_any = found && !bus.flush && !rst;

    always_comb begin
        grant = '0;
        if (grant_any)
            grant[win_idx] = 1'b1;
    end

    assign bus.ch_grant = grant;

    always_comb begin
        ptr_d    = ptr_q;
        valid_d  = 1'b0;
        tag_d    = '0;
        result_d = '0;
        store_d  = '0;
        branch_d = 1'b0;
        taken_d  = 1'b0;
        src_d    = '0;
        if (grant_any) begin
            if (RR_MODE != 0)
                ptr_d = (win_idx == LAST) ? '0 : win_idx + SRC_W'(1);
            valid_d  = 1'b1;
            tag_d    = bus.ch_tag[win_idx*TAG_W +: TAG_W];
            result_d = bus.ch_result[win_idx*DATA_W +: DATA_W];
            store_d  = bus.ch_store_data[win_idx*DATA_W +: DATA_W];
            branch_d = bus.ch_branch[win_idx];
            taken_d  = bus.ch_branch_taken[win_idx];
            src_d    = win_idx;
        end
    end

    // Broadcast register: idle cycles load zeros so the bus reads clean when not valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            valid_q  <= 1'b0;
            tag_q    <= '0;
            result_q <= '0;
            store_q  <= '0;
            branch_q <= 1'b0;
            taken_q  <= 1'b0;
            src_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            store_q  <= store_d;
            branch_q <= branch_d;
            taken_q  <= taken_d;
            src_q    <= src_d;
        end
    end

    assign bus.cdb_valid        = valid_q;
    assign bus.cdb_tag          = tag_q;
    assign bus.cdb_result       = result_q;
    assign bus.cdb_store_data   = store_q;
    assign bus.cdb_branch       = branch_q;
    assign bus.cdb_branch_taken = taken_q;
    assign bus.cdb_src          = src_q;
endmodule
